// File: rtl/npu_conv_pkg.sv
// Shared types and kernel defaults for the conv
// sequencer and its address generator.
package npu_conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FETCH,
    WRITE,
    DONE
  } state_e;

  localparam int KH_DEF = 3;
  localparam int KW_DEF = 3;
  localparam int IN_DW_DEF = 9;

  function automatic int calc_nk(input int kh, input int kw);
    return kh * kw;
  endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Maps (r, c, k) to kernel row/col and to the ifm
// and ofm buffer addresses.
module conv_win_addr_gen #(
  parameter int IMG_W  = 4,
  parameter int OW     = 2,
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int ADDR_W = 10,
  parameter int KW     = 4
) (
  input  logic [ADDR_W-1:0] r_i,
  input  logic [ADDR_W-1:0] c_i,
  input  logic [KW-1:0]     k_i,
  output logic [ADDR_W-1:0] i_o,
  output logic [ADDR_W-1:0] j_o,
  output logic [ADDR_W-1:0] ifm_addr_o,
  output logic [ADDR_W-1:0] ofm_addr_o
);

  // Row/col split via a compare chain on row starts; no divider.
  always_comb begin
    i_o = '0;
    j_o = ADDR_W'(k_i);
    for (int ii = 1; ii < K_H; ii++) begin
      if (ADDR_W'(k_i) >= ADDR_W'(ii * K_W)) begin
        i_o = ADDR_W'(ii);
        j_o = ADDR_W'(k_i) - ADDR_W'(ii * K_W);
      end
    end
  end

  assign ifm_addr_o = (r_i + i_o) * ADDR_W'(IMG_W)
                    + c_i + j_o;
  assign ofm_addr_o = r_i * ADDR_W'(OW) + c_i;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Layer sequencer: loads weights, walks output positions,
// gathers each input window and writes the conv result.
module conv_seq_ctrl
  import npu_conv_pkg::*;
#(
  parameter int IMG_H         = 4,
  parameter int IMG_W         = 4,
  parameter int K_H           = KH_DEF,
  parameter int K_W           = KW_DEF,
  parameter int IN_DATA_WIDTH = IN_DW_DEF,
  parameter int ADDR_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en_relu_cfg,
  output logic busy,
  output logic done,
  output logic wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [7:0] wgt_rd_data,
  output logic ifm_rd_en,
  output logic [ADDR_W-1:0] ifm_rd_addr,
  input  logic [IN_DATA_WIDTH-1:0] ifm_rd_data,
  output logic [K_H*K_W*IN_DATA_WIDTH-1:0] conv_win_o,
  output logic [K_H*K_W*8-1:0] w_o,
  output logic en_relu_o,
  input  logic [7:0] conv_pixel_i,
  output logic ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_wr_addr,
  output logic [7:0] ofm_wr_data
);

  localparam int NK = calc_nk(K_H, K_W);
  localparam int OH = IMG_H - K_H + 1;
  localparam int OW = IMG_W - K_W + 1;
  localparam int KW = $clog2(NK + 1);
  localparam int WW = NK * IN_DATA_WIDTH;

  if (IMG_H * IMG_W > (1 << ADDR_W)) begin : g_addr_chk
    $error("conv_seq_ctrl: IMG_H*IMG_W does not fit ADDR_W");
  end
  if (IMG_H < K_H || IMG_W < K_W) begin : g_size_chk
    $error("conv_seq_ctrl: image smaller than kernel");
  end

  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [WW-1:0] win_q, win_d;
  logic [NK*8-1:0] w_q, w_d;
  logic relu_q, relu_d;

  logic [ADDR_W-1:0] ifm_addr;
  logic [ADDR_W-1:0] ofm_addr;
  logic [ADDR_W-1:0] ij_unused_i;
  logic [ADDR_W-1:0] ij_unused_j;
  logic k_last;
  logic pos_last;

  conv_win_addr_gen #(
    .IMG_W  (IMG_W),
    .OW     (OW),
    .K_H    (K_H),
    .K_W    (K_W),
    .ADDR_W (ADDR_W),
    .KW     (KW)
  ) u_addr (
    .r_i        (r_q),
    .c_i        (c_q),
    .k_i        (k_q),
    .i_o        (ij_unused_i),
    .j_o        (ij_unused_j),
    .ifm_addr_o (ifm_addr),
    .ofm_addr_o (ofm_addr)
  );

  assign k_last   = (k_q == KW'(NK));
  assign pos_last = (r_q == ADDR_W'(OH - 1))
                 && (c_q == ADDR_W'(OW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      win_q   <= '0;
      w_q     <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      win_q   <= win_d;
      w_q     <= w_d;
      relu_q  <= relu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    win_d   = win_q;
    w_d     = w_q;
    relu_d  = relu_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          k_d     = '0;
          relu_d  = en_relu_cfg;
        end
      end
      LOAD_W: begin
        // Read data lags its strobe by one cycle.
        for (int n = 0; n < NK; n++) begin
          if (k_q == KW'(n + 1)) w_d[n*8 +: 8] = wgt_rd_data;
        end
        if (k_last) begin
          state_d = FETCH;
          k_d     = '0;
          r_d     = '0;
          c_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      FETCH: begin
        for (int n = 0; n < NK; n++) begin
          if (k_q == KW'(n + 1)) begin
            win_d[n*IN_DATA_WIDTH +: IN_DATA_WIDTH] = ifm_rd_data;
          end
        end
        if (k_last) begin
          state_d = WRITE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      WRITE: begin
        if (pos_last) begin
          state_d = DONE;
          r_d     = '0;
          c_d     = '0;
        end else begin
          state_d = FETCH;
          if (c_q == ADDR_W'(OW - 1)) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  assign wgt_rd_en   = (state_q == LOAD_W) && !k_last;
  assign wgt_rd_addr = wgt_rd_en ? ADDR_W'(k_q) : '0;
  assign ifm_rd_en   = (state_q == FETCH) && !k_last;
  assign ifm_rd_addr = ifm_rd_en ? ifm_addr : '0;
  assign ofm_wr_en   = (state_q == WRITE);
  assign ofm_wr_addr = ofm_wr_en ? ofm_addr : '0;
  assign ofm_wr_data = ofm_wr_en ? conv_pixel_i : '0;

  assign conv_win_o = win_q;
  assign w_o        = w_q;
  assign en_relu_o  = relu_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl with memory and
// conv-unit models around two differently sized instances.
module tb_conv_seq_ctrl;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    int         t;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   t0_a;
  int   t0_b;
  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  logic signed [7:0] wgt_mem [9];
  logic signed [8:0] ifm_mem_a [16];
  logic signed [8:0] ifm_mem_b [30];

  logic start_a, relu_cfg_a, busy_a, done_a;
  logic wgt_en_a, ifm_en_a, ofm_en_a, relu_a;
  logic [9:0] wgt_addr_a, ifm_addr_a, ofm_addr_a;
  logic [7:0] wgt_data_a, pix_a, ofm_data_a;
  logic [8:0] ifm_data_a;
  logic [80:0] win_a;
  logic [71:0] w_a;

  logic start_b, relu_cfg_b, busy_b, done_b;
  logic wgt_en_b, ifm_en_b, ofm_en_b, relu_b;
  logic [9:0] wgt_addr_b, ifm_addr_b, ofm_addr_b;
  logic [7:0] wgt_data_b, pix_b, ofm_data_b;
  logic [8:0] ifm_data_b;
  logic [80:0] win_b;
  logic [71:0] w_b;

  conv_seq_ctrl u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .start        (start_a),
    .en_relu_cfg  (relu_cfg_a),
    .busy         (busy_a),
    .done         (done_a),
    .wgt_rd_en    (wgt_en_a),
    .wgt_rd_addr  (wgt_addr_a),
    .wgt_rd_data  (wgt_data_a),
    .ifm_rd_en    (ifm_en_a),
    .ifm_rd_addr  (ifm_addr_a),
    .ifm_rd_data  (ifm_data_a),
    .conv_win_o   (win_a),
    .w_o          (w_a),
    .en_relu_o    (relu_a),
    .conv_pixel_i (pix_a),
    .ofm_wr_en    (ofm_en_a),
    .ofm_wr_addr  (ofm_addr_a),
    .ofm_wr_data  (ofm_data_a)
  );

  conv_seq_ctrl #(
    .IMG_H (5),
    .IMG_W (6)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .start        (start_b),
    .en_relu_cfg  (relu_cfg_b),
    .busy         (busy_b),
    .done         (done_b),
    .wgt_rd_en    (wgt_en_b),
    .wgt_rd_addr  (wgt_addr_b),
    .wgt_rd_data  (wgt_data_b),
    .ifm_rd_en    (ifm_en_b),
    .ifm_rd_addr  (ifm_addr_b),
    .ifm_rd_data  (ifm_data_b),
    .conv_win_o   (win_b),
    .w_o          (w_b),
    .en_relu_o    (relu_b),
    .conv_pixel_i (pix_b),
    .ofm_wr_en    (ofm_en_b),
    .ofm_wr_addr  (ofm_addr_b),
    .ofm_wr_data  (ofm_data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffers: one-cycle read latency.
  initial begin
    wgt_data_a = '0;
    ifm_data_a = '0;
    wgt_data_b = '0;
    ifm_data_b = '0;
  end
  always @(posedge clk) begin
    if (wgt_en_a) wgt_data_a <= wgt_mem[wgt_addr_a];
    if (ifm_en_a) ifm_data_a <= ifm_mem_a[ifm_addr_a];
    if (wgt_en_b) wgt_data_b <= wgt_mem[wgt_addr_b];
    if (ifm_en_b) ifm_data_b <= ifm_mem_b[ifm_addr_b];
  end

  function automatic logic [7:0] conv_f(
    input logic [80:0] win,
    input logic [71:0] w,
    input logic relu
  );
    int s = 0;
    for (int k = 0; k < 9; k++) begin
      s += int'($signed(win[k*9 +: 9]))
         * int'($signed(w[k*8 +: 8]));
    end
    if (relu && s < 0) s = 0;
    return 8'(s);
  endfunction

  assign pix_a = conv_f(win_a, w_a, relu_a);
  assign pix_b = conv_f(win_b, w_b, relu_b);

  function automatic logic [7:0] ref_a(
    input int r, input int c, input logic relu
  );
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(ifm_mem_a[(r+i)*4 + c + j])
           * int'(wgt_mem[i*3 + j]);
    if (relu && s < 0) s = 0;
    return 8'(s);
  endfunction

  function automatic logic [7:0] ref_b(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(ifm_mem_b[(r+i)*6 + c + j])
           * int'(wgt_mem[i*3 + j]);
    return 8'(s);
  endfunction

  // Write monitors and strobe exclusivity.
  always @(negedge clk) begin
    exp_t e;
    if (wgt_en_a || ifm_en_a || ofm_en_a) begin
      total++;
      if ($countones({wgt_en_a, ifm_en_a, ofm_en_a}) > 1) begin
        bad++;
        $display("FAIL strobe_a t=%0d got=%b want=onehot",
                 cyc - t0_a, {wgt_en_a, ifm_en_a, ofm_en_a});
      end
    end
    if (ofm_en_a) begin
      total++;
      if (exp_q_a.size() == 0) begin
        bad++;
        $display("FAIL wr_unexp_a t=%0d got addr=%0d want none",
                 cyc - t0_a, ofm_addr_a);
      end else begin
        e = exp_q_a.pop_front();
        if (ofm_addr_a !== e.addr || ofm_data_a !== e.data
            || (cyc - t0_a) != e.t) begin
          bad++;
          $display("FAIL wr_a got a=%0d d=%h t=%0d want a=%0d d=%h t=%0d",
                   ofm_addr_a, ofm_data_a, cyc - t0_a,
                   e.addr, e.data, e.t);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ofm_en_b) begin
      total++;
      if (exp_q_b.size() == 0) begin
        bad++;
        $display("FAIL wr_unexp_b t=%0d got addr=%0d want none",
                 cyc - t0_b, ofm_addr_b);
      end else begin
        e = exp_q_b.pop_front();
        if (ofm_addr_b !== e.addr || ofm_data_b !== e.data
            || (cyc - t0_b) != e.t) begin
          bad++;
          $display("FAIL wr_b got a=%0d d=%h t=%0d want a=%0d d=%h t=%0d",
                   ofm_addr_b, ofm_data_b, cyc - t0_b,
                   e.addr, e.data, e.t);
        end
      end
    end
  end

  task automatic check_zero_a(input string nm);
    logic [249:0] v;
    v = {busy_a, done_a, wgt_en_a, wgt_addr_a, ifm_en_a,
         ifm_addr_a, win_a, w_a, relu_a, ofm_en_a,
         ofm_addr_a, ofm_data_a};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s got=%h want=0", nm, v);
    end
  endtask

  task automatic run_a(
    input logic relu,
    input bit   re_start,
    input bit   rst_pulse,
    input bit   chk_seq
  );
    int t;
    bit fin;
    bit saw_done;
    logic [9:0] seq[$];
    logic [9:0] seq_exp [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    exp_q_a.delete();
    for (int n = 0; n < 4; n++) begin
      exp_q_a.push_back('{addr: 10'(n),
                          data: ref_a(n / 2, n % 2, relu),
                          t: 20 + n * 11});
    end
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL busy_idle got=%b want=0", busy_a);
    end
    relu_cfg_a = relu;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    t0_a = cyc;
    fin = 0;
    saw_done = 0;
    for (int g = 0; g < 200 && !fin; g++) begin
      @(negedge clk);
      t = cyc - t0_a;
      if (t == 0) begin
        total++;
        if (busy_a !== 1'b1 || relu_a !== relu) begin
          bad++;
          $display("FAIL busy_rise got=%b%b want=1%b",
                   busy_a, relu_a, relu);
        end
      end
      if (re_start && t == 25) begin
        start_a = 1'b1;
        relu_cfg_a = ~relu;
      end
      if (re_start && t == 26) begin
        start_a = 1'b0;
        relu_cfg_a = relu;
      end
      if (re_start && t == 27) begin
        total++;
        if (relu_a !== relu || busy_a !== 1'b1) begin
          bad++;
          $display("FAIL restart_ign got=%b%b want=%b1",
                   relu_a, busy_a, relu);
        end
      end
      if (chk_seq && ifm_en_a && t >= 21 && t <= 29)
        seq.push_back(ifm_addr_a);
      if (rst_pulse) begin
        if (t == 25) rst = 1'b1;
        if (t == 26) begin
          rst = 1'b0;
          exp_q_a.delete();
          check_zero_a("rst_mid_zero");
        end
        if (done_a) saw_done = 1;
        if (t == 70) begin
          total++;
          if (saw_done) begin
            bad++;
            $display("FAIL rst_no_done got=1 want=0");
          end
          fin = 1;
        end
      end else if (done_a) begin
        total++;
        if (t != 54) begin
          bad++;
          $display("FAIL done_t got=%0d want=54", t);
        end
        @(negedge clk);
        total++;
        if (busy_a !== 1'b0) begin
          bad++;
          $display("FAIL busy_fall got=%b want=0", busy_a);
        end
        fin = 1;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL timeout_a got=no_done want=done");
    end
    if (!rst_pulse) begin
      total++;
      if (exp_q_a.size() != 0) begin
        bad++;
        $display("FAIL missing_wr_a got=%0d left want=0",
                 exp_q_a.size());
      end
    end
    if (chk_seq) begin
      total++;
      if (seq.size() != 9) begin
        bad++;
        $display("FAIL ifm_seq_len got=%0d want=9", seq.size());
      end else begin
        for (int i = 0; i < 9; i++) begin
          if (seq[i] !== seq_exp[i]) begin
            bad++;
            $display("FAIL ifm_seq[%0d] got=%0d want=%0d",
                     i, seq[i], seq_exp[i]);
            break;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0;
    relu_cfg_a = 1'b0;
    start_b = 1'b0;
    relu_cfg_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_a("reset_a");
    total++;
    if ({busy_b, done_b, ofm_en_b, wgt_en_b, ifm_en_b,
         win_b, w_b} !== '0) begin
      bad++;
      $display("FAIL reset_b got=nonzero want=0");
    end
    rst = 1'b0;
  endtask

  task automatic load_ones();
    for (int k = 0; k < 9; k++) wgt_mem[k] = 8'sd1;
    for (int a = 0; a < 16; a++) ifm_mem_a[a] = 9'sd1;
  endtask

  task automatic test_ones();
    load_ones();
    run_a(1'b0, 0, 0, 0);
  endtask

  task automatic test_neg();
    for (int k = 0; k < 9; k++) wgt_mem[k] = -8'sd1;
    run_a(1'b0, 0, 0, 0);
    run_a(1'b1, 0, 0, 0);
  endtask

  task automatic test_centre();
    for (int k = 0; k < 9; k++) wgt_mem[k] = (k == 4) ? 8'sd1 : 8'sd0;
    for (int a = 0; a < 16; a++) ifm_mem_a[a] = 9'(a);
    run_a(1'b0, 0, 0, 1);
  endtask

  task automatic test_restart();
    load_ones();
    run_a(1'b0, 1, 0, 0);
  endtask

  task automatic test_rst_mid();
    load_ones();
    run_a(1'b0, 0, 1, 0);
    run_a(1'b0, 0, 0, 0);
  endtask

  task automatic test_big();
    int t;
    bit fin;
    for (int k = 0; k < 9; k++) wgt_mem[k] = 8'sd1;
    for (int a = 0; a < 30; a++) ifm_mem_b[a] = 9'(a % 7);
    exp_q_b.delete();
    for (int n = 0; n < 12; n++) begin
      exp_q_b.push_back('{addr: 10'(n),
                          data: ref_b(n / 4, n % 4),
                          t: 20 + n * 11});
    end
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    t0_b = cyc;
    fin = 0;
    for (int g = 0; g < 300 && !fin; g++) begin
      @(negedge clk);
      t = cyc - t0_b;
      if (done_b) begin
        total++;
        if (t != 20 + 11 * 11 + 1) begin
          bad++;
          $display("FAIL done_b_t got=%0d want=%0d", t, 142);
        end
        fin = 1;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL timeout_b got=no_done want=done");
    end
    total++;
    if (exp_q_b.size() != 0) begin
      bad++;
      $display("FAIL missing_wr_b got=%0d left want=0",
               exp_q_b.size());
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    t0_a = 0;
    t0_b = 0;
    test_reset();
    test_ones();
    test_neg();
    test_centre();
    test_restart();
    test_rst_mid();
    test_big();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
